data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit_if.sv | 22 ++
 rtl/data_mem_unit.sv | 121 ++++++++++++
 tb/tb_data_mem_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_unit_if.sv
// Load/store request and response bundle between pipeline MEM stage and the data memory.
// Requests are held by the pipeline while stall is high; responses are single-cycle pulses.
interface data_mem_unit_if;
   logic        memread;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        ready;
   logic        addr_err;

   modport master (
      output memread, memwrite, addr, wdata,
      input  rdata, stall, ready, addr_err
   );

   modport slave (
      input  memread, memwrite, addr, wdata,
      output rdata, stall, ready, addr_err
   );
endinterface

// File: rtl/data_mem_unit.sv
// Multi-cycle word data memory: WAIT busy cycles then a one-cycle DONE with ready; illegal requests pulse addr_err.
// Latency WAIT+1 edges from request cycle to ready; stall freezes the pipeline until DONE.
module data_mem_unit #(
   parameter int DEPTH = 256,
   parameter int WAIT  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   data_mem_unit_if.slave  bus
);
   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'(WAIT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic          wr_q;
   logic [31:0]   rdata_q;
   logic          ready_q;
   logic          err_q;
   logic          stall;
   logic          req;
   logic          legal;
   logic          accept;
   logic          reject;
   logic          finish;

   logic [31:0]   mem [DEPTH];

   assign req   = bus.memread | bus.memwrite;
   assign legal = (bus.memread ^ bus.memwrite) &&
                  (bus.addr[1:0] == 2'b00) &&
                  ({2'b00, bus.addr[31:2]} < DEPTH_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            stall = req;
            if (req) begin
               if (legal) begin
                  accept    = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt == 4'd0) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are captured once; the live inputs are don't-care until back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= 4'd0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
      end else if (accept) begin
         cnt     <= CNT_INIT;
         idx_q   <= bus.addr[AW+1:2];
         wdata_q <= bus.wdata;
         wr_q    <= bus.memwrite;
      end else if (state == BUSY && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= finish;
         err_q   <= reject;
         if (reject) begin
            rdata_q <= '0;
         end else if (finish && !wr_q) begin
            rdata_q <= mem[idx_q];
         end
      end
   end

   // No reset on the array; a reset in BUSY drops state to IDLE so finish never fires.
   always_ff @(posedge clk) begin
      if (finish && wr_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign bus.stall    = stall;
   assign bus.rdata    = rdata_q;
   assign bus.ready    = ready_q;
   assign bus.addr_err = err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit with DEPTH=256, WAIT=2.
module tb_data_mem_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   fails  = 0;

   data_mem_unit_if bus();

   data_mem_unit #(.DEPTH(256), .WAIT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Drives one request in the current IDLE cycle, drops it after the first edge, observes 10 cycles.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output int n_stall, output int n_ready, output int n_err,
                            output int ready_at, output int err_at, output logic overlap,
                            output logic [31:0] rd_last);
      n_stall = 0; n_ready = 0; n_err = 0; ready_at = 0; err_at = 0; overlap = 1'b0;
      bus.memread = rd; bus.memwrite = wr; bus.addr = a; bus.wdata = d;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.stall) n_stall++;
         if (bus.ready) begin n_ready++; if (ready_at == 0) ready_at = c; end
         if (bus.addr_err) begin n_err++; if (err_at == 0) err_at = c; end
         if (bus.ready && bus.addr_err) overlap = 1'b1;
         @(posedge clk); #1;
         if (c == 1) begin
            bus.memread = 1'b0; bus.memwrite = 1'b0;
            bus.addr = 32'h3; bus.wdata = 32'hFFFF_FFFF;
         end
      end
      rd_last = bus.rdata;
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d);
      int s, r, e, ra, ea;
      logic ov;
      logic [31:0] q;
      do_access(1'b0, 1'b1, a, d, s, r, e, ra, ea, ov, q);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.memread = 1'b0; bus.memwrite = 1'b0; bus.addr = '0; bus.wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      checks++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
      checks++; if (bus.addr_err !== 1'b0) begin fails++; $display("FAIL reset_addr_err: got %b expected 0", bus.addr_err); end
      checks++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
      bus.memread = 1'b1;
      #1;
      checks++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL reset_stall_req: got %b expected 1", bus.stall); end
      bus.memread = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_store_load;
      int s, r, e, ra, ea;
      logic ov;
      logic [31:0] q;
      do_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, s, r, e, ra, ea, ov, q);
      checks++; if (s !== 3) begin fails++; $display("FAIL store_stall_cycles: got %0d expected 3", s); end
      checks++; if (r !== 1) begin fails++; $display("FAIL store_ready_pulses: got %0d expected 1", r); end
      checks++; if (ra !== 4) begin fails++; $display("FAIL store_first_after_reset_latency: got cycle %0d expected 4", ra); end
      checks++; if (e !== 0) begin fails++; $display("FAIL store_addr_err: got %0d expected 0", e); end
      do_access(1'b1, 1'b0, 32'h10, 32'h0, s, r, e, ra, ea, ov, q);
      checks++; if (s !== 3) begin fails++; $display("FAIL load_stall_cycles: got %0d expected 3", s); end
      checks++; if (r !== 1) begin fails++; $display("FAIL load_ready_pulses: got %0d expected 1", r); end
      checks++; if (ra !== 4) begin fails++; $display("FAIL load_latency: got cycle %0d expected 4", ra); end
      checks++; if (q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_rdata: got %h expected deadbeef", q); end
      do_access(1'b0, 1'b1, 32'h14, 32'h1111_1111, s, r, e, ra, ea, ov, q);
      checks++; if (q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rdata_hold_on_store: got %h expected deadbeef", q); end
   endtask

   task automatic test_misaligned;
      int s, r, e, ra, ea;
      logic ov;
      logic [31:0] q;
      do_access(1'b1, 1'b0, 32'h13, 32'h0, s, r, e, ra, ea, ov, q);
      checks++; if (e !== 1) begin fails++; $display("FAIL misaligned_err_pulses: got %0d expected 1", e); end
      checks++; if (ea !== 2) begin fails++; $display("FAIL misaligned_err_cycle: got %0d expected 2", ea); end
      checks++; if (s !== 1) begin fails++; $display("FAIL misaligned_stall_cycles: got %0d expected 1", s); end
      checks++; if (r !== 0) begin fails++; $display("FAIL misaligned_ready: got %0d expected 0", r); end
      checks++; if (q !== 32'h0) begin fails++; $display("FAIL misaligned_rdata: got %h expected 0", q); end
   endtask

   task automatic test_conflict;
      int s, r, e, ra, ea;
      logic ov;
      logic [31:0] q;
      write_word(32'h20, 32'hCAFE_F00D);
      do_access(1'b1, 1'b1, 32'h20, 32'h0BAD_0BAD, s, r, e, ra, ea, ov, q);
      checks++; if (e !== 1) begin fails++; $display("FAIL conflict_err_pulses: got %0d expected 1", e); end
      checks++; if (r !== 0) begin fails++; $display("FAIL conflict_ready: got %0d expected 0", r); end
      checks++; if (ov !== 1'b0) begin fails++; $display("FAIL conflict_ready_err_overlap: got %b expected 0", ov); end
      do_access(1'b1, 1'b0, 32'h20, 32'h0, s, r, e, ra, ea, ov, q);
      checks++; if (q !== 32'hCAFE_F00D) begin fails++; $display("FAIL conflict_word_unchanged: got %h expected cafef00d", q); end
   endtask

   task automatic test_out_of_range;
      int s, r, e, ra, ea;
      logic ov;
      logic [31:0] q;
      write_word(32'h0, 32'h0102_0304);
      do_access(1'b0, 1'b1, 32'h400, 32'h5A5A_5A5A, s, r, e, ra, ea, ov, q);
      checks++; if (e !== 1) begin fails++; $display("FAIL range_store_err: got %0d expected 1", e); end
      checks++; if (s !== 1) begin fails++; $display("FAIL range_store_stall_cycles: got %0d expected 1", s); end
      do_access(1'b1, 1'b0, 32'h400, 32'h0, s, r, e, ra, ea, ov, q);
      checks++; if (r !== 0) begin fails++; $display("FAIL range_load_ready: got %0d expected 0", r); end
      checks++; if (q !== 32'h0) begin fails++; $display("FAIL range_load_rdata: got %h expected 0", q); end
      do_access(1'b1, 1'b0, 32'h0, 32'h0, s, r, e, ra, ea, ov, q);
      checks++; if (q !== 32'h0102_0304) begin fails++; $display("FAIL range_no_alias_write: got %h expected 01020304", q); end
   endtask

   task automatic test_reset_store;
      int s, r, e, ra, ea;
      logic ov;
      logic [31:0] q;
      write_word(32'h08, 32'h0);
      bus.memwrite = 1'b1; bus.addr = 32'h08; bus.wdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus.memwrite = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
      checks++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL rst_store_busy: got stall %b expected 1", bus.stall); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rst_store_stall: got %b expected 0", bus.stall); end
      checks++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL rst_store_ready: got %b expected 0", bus.ready); end
      checks++; if (bus.addr_err !== 1'b0) begin fails++; $display("FAIL rst_store_addr_err: got %b expected 0", bus.addr_err); end
      checks++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL rst_store_rdata: got %h expected 0", bus.rdata); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_access(1'b1, 1'b0, 32'h08, 32'h0, s, r, e, ra, ea, ov, q);
      checks++; if (ra !== 4) begin fails++; $display("FAIL rst_store_reload_latency: got cycle %0d expected 4", ra); end
      checks++; if (q !== 32'h0) begin fails++; $display("FAIL rst_store_aborted: got %h expected 0", q); end
   endtask

   task automatic test_back_to_back;
      int n_stall, n_ready, r1, r2;
      logic [31:0] q1, q2;
      n_stall = 0; n_ready = 0; r1 = 0; r2 = 0; q1 = '0; q2 = '0;
      write_word(32'h04, 32'h4444_4444);
      bus.memread = 1'b1; bus.addr = 32'h0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.stall) n_stall++;
         if (bus.ready) begin
            n_ready++;
            if (r1 == 0) begin r1 = c; q1 = bus.rdata; end
            else begin r2 = c; q2 = bus.rdata; end
         end
         @(posedge clk); #1;
         if (c == 1) bus.addr = 32'h4;
         if (c == 5) begin bus.memread = 1'b0; bus.addr = 32'h0; end
      end
      checks++; if (n_ready !== 2) begin fails++; $display("FAIL b2b_ready_pulses: got %0d expected 2", n_ready); end
      checks++; if (r1 !== 4) begin fails++; $display("FAIL b2b_first_ready: got cycle %0d expected 4", r1); end
      checks++; if (r2 !== 8) begin fails++; $display("FAIL b2b_second_ready: got cycle %0d expected 8", r2); end
      checks++; if (n_stall !== 6) begin fails++; $display("FAIL b2b_stall_cycles: got %0d expected 6", n_stall); end
      checks++; if (q1 !== 32'h0102_0304) begin fails++; $display("FAIL b2b_first_rdata: got %h expected 01020304", q1); end
      checks++; if (q2 !== 32'h4444_4444) begin fails++; $display("FAIL b2b_second_rdata: got %h expected 44444444", q2); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_misaligned();
      test_conflict();
      test_out_of_range();
      test_reset_store();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
